// File: rtl/lc3_mem_pkg.sv
// Shared definitions for the two-port memory arbiter.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
// Contents: FSM state encoding, default bus widths, requester port IDs.
package lc3_mem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  localparam int DATA_W_DEF = 16;
  localparam int ADDR_W_DEF = 16;

  // Requester IDs as stored in the grant record.
  localparam logic PORT0 = 1'b0;  // CPU
  localparam logic PORT1 = 1'b1;  // IO/DMA

endpackage

// File: rtl/rr_pick2.sv
// Two-way round-robin picker: single requester wins, a tie goes to the port not granted last.
// Latency: purely combinational.
// Backpressure: none; the caller decides when the pick is consumed.
// Ports: req[1:0] requests, last_grant previous winner, vld any request, pick winning port ID.
module rr_pick2
  import lc3_mem_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic       vld,
  output logic       pick
);

  always_comb begin
    vld  = |req;
    pick = PORT0;
    if (req == 2'b11) begin
      pick = ~last_grant;
    end else if (req[1]) begin
      pick = PORT1;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Two-port (CPU, IO/DMA) arbiter onto a single memory, one transaction in flight at a time.
// Latency: req sampled cycle 0 -> mem_en cycle 1 -> mem_r cycle 2 -> ack cycle 3; at most one transaction per 4 cycles.
// Backpressure: requests are only sampled in IDLE; requesters hold req/rw/addr/wdata until their ack.
// Ports: clk/rst_n; per port reqN, rwN, addrN, wdataN in and ackN, errN, rdataN out;
//        memory side mem_en, mem_rw, mem_addr, mem_data out and mem_r, mem_out in.
module mem_arbiter
  import lc3_mem_pkg::*;
#(
  parameter int DATA_W      = DATA_W_DEF,
  parameter int ADDR_W      = ADDR_W_DEF,
  parameter int TIMEOUT_CYC = 15          // must be >= 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0,
  input  logic              req1,
  input  logic              rw0,
  input  logic              rw1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              ack0,
  output logic              ack1,
  output logic              err0,
  output logic              err1,
  output logic [DATA_W-1:0] rdata0,
  output logic [DATA_W-1:0] rdata1,
  output logic              mem_en,
  output logic              mem_rw,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_data,
  input  logic              mem_r,
  input  logic [DATA_W-1:0] mem_out
);

  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

  state_t            state, state_nxt;
  logic              grant, grant_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt, cnt_inc;
  logic              pick_vld, pick;

  logic              mem_en_nxt, mem_rw_nxt;
  logic [ADDR_W-1:0] mem_addr_nxt;
  logic [DATA_W-1:0] mem_data_nxt;
  logic              ack0_nxt, ack1_nxt, err0_nxt, err1_nxt;
  logic [DATA_W-1:0] rdata0_nxt, rdata1_nxt;

  rr_pick2 u_pick (
    .req        ({req1, req0}),
    .last_grant (grant),
    .vld        (pick_vld),
    .pick       (pick)
  );

  assign cnt_inc = cnt + CNT_W'(1);

  // The mem_* registers double as the latched request, so they stay stable
  // from ISSUE through RESP without a separate copy.
  always_comb begin
    state_nxt    = state;
    grant_nxt    = grant;
    cnt_nxt      = cnt;
    mem_en_nxt   = 1'b0;
    mem_rw_nxt   = mem_rw;
    mem_addr_nxt = mem_addr;
    mem_data_nxt = mem_data;
    ack0_nxt     = 1'b0;
    ack1_nxt     = 1'b0;
    err0_nxt     = 1'b0;
    err1_nxt     = 1'b0;
    rdata0_nxt   = rdata0;
    rdata1_nxt   = rdata1;

    case (state)
      ST_IDLE: begin
        if (pick_vld) begin
          grant_nxt    = pick;
          mem_rw_nxt   = (pick == PORT1) ? rw1    : rw0;
          mem_addr_nxt = (pick == PORT1) ? addr1  : addr0;
          mem_data_nxt = (pick == PORT1) ? wdata1 : wdata0;
          mem_en_nxt   = 1'b1;
          state_nxt    = ST_ISSUE;
        end
      end

      ST_ISSUE: begin
        cnt_nxt   = '0;
        state_nxt = ST_WAIT;
      end

      ST_WAIT: begin
        cnt_nxt = cnt_inc;
        if (mem_r || (cnt_inc == CNT_W'(TIMEOUT_CYC))) begin
          // mem_r wins over a timeout landing in the same cycle.
          state_nxt = ST_RESP;
          ack0_nxt  = (grant == PORT0);
          ack1_nxt  = (grant == PORT1);
          err0_nxt  = !mem_r && (grant == PORT0);
          err1_nxt  = !mem_r && (grant == PORT1);
          if (!mem_rw) begin
            if (grant == PORT0) rdata0_nxt = mem_r ? mem_out : '0;
            else                rdata1_nxt = mem_r ? mem_out : '0;
          end
        end
      end

      ST_RESP: begin
        state_nxt = ST_IDLE;
      end

      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      grant    <= PORT1;  // port 0 wins the first tie
      cnt      <= '0;
      mem_en   <= 1'b0;
      mem_rw   <= 1'b0;
      mem_addr <= '0;
      mem_data <= '0;
      ack0     <= 1'b0;
      ack1     <= 1'b0;
      err0     <= 1'b0;
      err1     <= 1'b0;
      rdata0   <= '0;
      rdata1   <= '0;
    end else begin
      state    <= state_nxt;
      grant    <= grant_nxt;
      cnt      <= cnt_nxt;
      mem_en   <= mem_en_nxt;
      mem_rw   <= mem_rw_nxt;
      mem_addr <= mem_addr_nxt;
      mem_data <= mem_data_nxt;
      ack0     <= ack0_nxt;
      ack1     <= ack1_nxt;
      err0     <= err0_nxt;
      err1     <= err1_nxt;
      rdata0   <= rdata0_nxt;
      rdata1   <= rdata1_nxt;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a one-cycle-latency memory responder.
// Latency: n/a.
// Backpressure: memory can be stalled (mem_r held low) to force timeouts.
module tb_mem_arbiter;
  import lc3_mem_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req0, req1, rw0, rw1;
  logic [15:0] addr0, addr1, wdata0, wdata1;
  logic        ack0, ack1, err0, err1;
  logic [15:0] rdata0, rdata1;
  logic        mem_en, mem_rw;
  logic [15:0] mem_addr, mem_data;
  logic        mem_r;
  logic [15:0] mem_out;

  logic [15:0] mem [0:255];
  logic        mem_stall;
  logic        pend;
  logic [15:0] pend_dat;

  int n_cmp = 0;
  int n_bad = 0;
  int n;

  always #5 clk = ~clk;

  mem_arbiter #(.DATA_W(16), .ADDR_W(16), .TIMEOUT_CYC(15)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .req1(req1), .rw0(rw0), .rw1(rw1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .ack0(ack0), .ack1(ack1), .err0(err0), .err1(err1),
    .rdata0(rdata0), .rdata1(rdata1),
    .mem_en(mem_en), .mem_rw(mem_rw), .mem_addr(mem_addr), .mem_data(mem_data),
    .mem_r(mem_r), .mem_out(mem_out)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one cycle; outputs are read 1 time unit after the edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ack(input int port, input int budget, output int cycles);
    cycles = 0;
    do begin
      cyc();
      cycles++;
    end while (((port == 0) ? ack0 : ack1) !== 1'b1 && cycles < budget);
  endtask

  // Memory responder: mem_en seen in cycle k gives mem_r/mem_out in cycle k+1.
  initial begin
    for (int i = 0; i < 256; i++) mem[i] = '0;
    mem[3] = 16'h1B61;
    mem[5] = 16'h5A5A;
    mem_r = 1'b0; mem_out = '0; pend = 1'b0; pend_dat = '0;
    forever begin
      cyc();
      mem_r   = pend;
      mem_out = pend_dat;
      pend    = mem_en && !mem_stall;
      if (mem_en) begin
        if (mem_rw) mem[mem_addr[7:0]] = mem_data;
        pend_dat = mem[mem_addr[7:0]];
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; mem_stall = 1'b0;
    req0 = 0; req1 = 0; rw0 = 0; rw1 = 0;
    addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;

    // Reset state
    repeat (3) cyc();
    check("rst_state", 32'(dut.state), 32'(ST_IDLE));
    check("rst_ack", {ack1, ack0, err1, err0}, 4'b0000);
    check("rst_mem_en", mem_en, 1'b0);
    check("rst_rdata", {rdata1, rdata0}, 32'h0);
    check("rst_mem_addr_data", {mem_addr, mem_data}, 32'h0);
    rst_n = 1'b1;
    cyc();

    // Single read by port 0
    req0 = 1; rw0 = 0; addr0 = 16'h0003;
    cyc();
    check("rd_c1_mem_en", mem_en, 1'b1);
    check("rd_c1_mem_addr", mem_addr, 16'h0003);
    check("rd_c1_mem_rw", mem_rw, 1'b0);
    cyc();
    check("rd_c2_mem_en", mem_en, 1'b0);
    check("rd_c2_ack0", ack0, 1'b0);
    cyc();
    check("rd_c3_ack0", ack0, 1'b1);
    check("rd_c3_err0", err0, 1'b0);
    check("rd_c3_rdata0", rdata0, 16'h1B61);
    check("rd_c3_ack1", ack1, 1'b0);
    cyc();
    req0 = 0;
    check("rd_c4_ack0_pulse", ack0, 1'b0);
    check("rd_c4_rdata0_hold", rdata0, 16'h1B61);

    // Round-robin from reset, both held: port 0 acks at 3 and 11, port 1 at 7 and 15
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
    cyc();
    req0 = 1; rw0 = 0; addr0 = 16'h0003;
    req1 = 1; rw1 = 0; addr1 = 16'h0005;
    for (int c = 1; c <= 15; c++) begin
      cyc();
      check($sformatf("rr_ack0_c%0d", c), ack0, (c == 3 || c == 11));
      check($sformatf("rr_ack1_c%0d", c), ack1, (c == 7 || c == 15));
    end
    check("rr_rdata0", rdata0, 16'h1B61);
    check("rr_rdata1", rdata1, 16'h5A5A);
    cyc();
    req0 = 0; req1 = 0;
    cyc();

    // Port 1 writes 0xBEEF to 0x0010, port 0 reads it back
    req1 = 1; rw1 = 1; addr1 = 16'h0010; wdata1 = 16'hBEEF;
    cyc();
    check("wr_c1_mem", {15'b0, mem_en, mem_rw, mem_addr[14:0]}, {15'b0, 1'b1, 1'b1, 15'h0010});
    check("wr_c1_mem_data", mem_data, 16'hBEEF);
    cyc();
    cyc();
    check("wr_ack1", ack1, 1'b1);
    check("wr_err1", err1, 1'b0);
    check("wr_ack0", ack0, 1'b0);
    check("wr_rdata1_hold", rdata1, 16'h5A5A);
    cyc();
    req1 = 0; rw1 = 0;
    req0 = 1; rw0 = 0; addr0 = 16'h0010;
    wait_ack(0, 20, n);
    check("rb_latency", n, 3);
    check("rb_rdata0", rdata0, 16'hBEEF);
    cyc();
    req0 = 0;
    cyc();

    // Timeout with memory never answering, then a normal read
    mem_stall = 1'b1;
    req0 = 1; rw0 = 0; addr0 = 16'h0003;
    wait_ack(0, 40, n);
    check("to_latency", n, 17);
    check("to_err0", err0, 1'b1);
    check("to_rdata0", rdata0, 16'h0000);
    check("to_ack1", ack1, 1'b0);
    cyc();
    req0 = 0; mem_stall = 1'b0;
    cyc();
    req0 = 1;
    wait_ack(0, 20, n);
    check("after_to_latency", n, 3);
    check("after_to_err0", err0, 1'b0);
    check("after_to_rdata0", rdata0, 16'h1B61);
    cyc();
    req0 = 0;
    cyc();

    // Reset during WAIT abandons the transaction
    req0 = 1; rw0 = 0; addr0 = 16'h0003;
    cyc();
    cyc();
    check("rw_in_wait", 32'(dut.state), 32'(ST_WAIT));
    rst_n = 1'b0;
    cyc();
    req0 = 0; rst_n = 1'b1;
    check("rw_state_idle", 32'(dut.state), 32'(ST_IDLE));
    check("rw_mem_en", mem_en, 1'b0);
    check("rw_ack0", ack0, 1'b0);
    for (int c = 0; c < 4; c++) begin
      cyc();
      check($sformatf("rw_no_ack_%0d", c), {ack1, ack0}, 2'b00);
    end
    req1 = 1; rw1 = 0; addr1 = 16'h0005;
    cyc();
    check("rw_req1_mem_en", mem_en, 1'b1);
    check("rw_req1_mem_addr", mem_addr, 16'h0005);
    cyc();
    cyc();
    check("rw_req1_ack1", ack1, 1'b1);
    check("rw_req1_rdata1", rdata1, 16'h5A5A);
    check("rw_req1_ack0", ack0, 1'b0);
    cyc();
    req1 = 0;
    cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter DATA_W, default 16: width of the data bus.
REQ-002 Parameter ADDR_W, default 16: width of the address bus.
REQ-003 Parameter TIMEOUT_CYC, default 15: maximum cycles spent in WAIT before an error response.
REQ-004 Port clk, input, 1: the single clock; all state SHALL update on its rising edge.
REQ-005 Port rst_n, input, 1: synchronous, active-low reset.
REQ-006 Ports req0/req1, input, 1: request from port 0 (CPU) and port 1 (IO/DMA).
REQ-007 Ports rw0/rw1, input, 1: 1 = write, 0 = read.
REQ-008 Ports addr0/addr1, input, ADDR_W: request address.
REQ-009 Ports wdata0/wdata1, input, DATA_W: write data.
REQ-010 Ports ack0/ack1, output, 1: one-cycle completion pulse.
REQ-011 Ports err0/err1, output, 1: timeout flag; valid only while the matching ack is high.
REQ-012 Ports rdata0/rdata1, output, DATA_W: read data; valid while the matching ack is high.
REQ-013 Memory-side ports: mem_en (out, 1), mem_rw (out, 1), mem_addr (out, ADDR_W), mem_data (out, DATA_W), mem_r (in, 1), mem_out (in, DATA_W).

Function
REQ-014 States SHALL be IDLE, ISSUE, WAIT and RESP; all outputs SHALL be registered.
REQ-015 IDLE with at least one req high: latch the winner's rw, addr and wdata; record the winner in grant; go to ISSUE.
REQ-016 Arbitration SHALL be round-robin: with a single requester, that requester wins; with both, the port not granted last wins.
REQ-017 ISSUE: mem_en=1 for exactly one cycle with the latched rw/addr/data; go to WAIT.
REQ-018 WAIT: count cycles; on mem_r=1, capture mem_out (reads only) and go to RESP.
REQ-019 WAIT timeout: when the count reaches TIMEOUT_CYC without mem_r, go to RESP with err set and rdata=0.
REQ-020 RESP: ack[grant]=1 and err[grant] as set; the other port's ack/err SHALL be 0; go to IDLE.
REQ-021 Nominal latency: req sampled in cycle 0 -> mem_en in cycle 1 -> mem_r in cycle 2 -> ack in cycle 3; throughput SHALL be at most one transaction per 4 cycles.
REQ-022 Requests arriving outside IDLE SHALL NOT be sampled; requesters SHALL hold req/rw/addr/wdata until ack and drop req in the cycle after ack.
REQ-023 A req still high in IDLE after its ack SHALL be treated as a new transaction.
REQ-024 rdataN SHALL hold its last value between acks; the write path SHALL NOT modify rdataN.
REQ-025 mem_r arriving outside WAIT SHALL be ignored.
REQ-026 mem_rw, mem_addr and mem_data SHALL remain stable from ISSUE through RESP.

Reset
REQ-027 While rst_n=0 at a clock edge: state=IDLE; mem_en, ack*, err*=0; rdata*, mem_addr, mem_data=0; timeout counter=0; grant record=1, so port 0 wins the first tie.
REQ-028 Reset mid-transaction SHALL abandon the transaction with no ack, and mem_en SHALL be low in the first cycle after reset.

Structure
REQ-029 Shared package lc3_mem_pkg SHALL hold the state encoding, DATA_W/ADDR_W defaults and the port-ID constants.
REQ-030 The arbitration decision SHALL live in a sub-module rr_pick2, a purely combinational 2-way round-robin picker taking req[1:0] and the last grant.

Verification
REQ-031 req0 read of 0x0003 with memory value 0x1B61 -> mem_en in cycle 1, ack0 and rdata0=0x1B61 in cycle 3, ack1 never asserted.
REQ-032 req0 and req1 both raised together from reset, held continuously -> grants alternate 0, 1, 0, 1, with acks 4 cycles apart.
REQ-033 req1 write of 0xBEEF to 0x0010, then req0 read of 0x0010 -> ack1 with err1=0, then rdata0=0xBEEF.
REQ-034 mem_r tied to 0, req0 read -> ack0 with err0=1 and rdata0=0 after TIMEOUT_CYC WAIT cycles; the next request completes normally.
REQ-035 rst_n pulled low during WAIT -> no ack, state IDLE, mem_en=0; a subsequent req1 is serviced with nominal latency.
